// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: one 2*XLEN x C partial product per stage,
// tag/ROB index carried alongside, valid/ready result port to the CDB arbiter.
module mult_fu #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int PRN_W      = 6,
  parameter int ROB_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [1:0]       in_func,
  input  logic [PRN_W-1:0] in_prn,
  input  logic [ROB_W-1:0] in_rob,
  input  logic             squash,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [PRN_W-1:0] out_prn,
  output logic [ROB_W-1:0] out_rob
);

  localparam int W2 = 2 * XLEN;
  localparam int C  = W2 / NUM_STAGES;
  localparam int NI = NUM_STAGES - 1;

  localparam logic [1:0] F_MUL    = 2'd0;
  localparam logic [1:0] F_MULH   = 2'd1;
  localparam logic [1:0] F_MULHSU = 2'd2;

  // Handshake: a result leaves when out_valid && out_ready; an op enters when
  // in_valid && in_ready. The whole pipe moves as one when advance is high.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [W2-1:0] ext_a, ext_b;
  logic          sign_a, sign_b;

  always_comb begin
    sign_a = (in_func == F_MULH) || (in_func == F_MULHSU);
    sign_b = (in_func == F_MULH);
    ext_a  = {{XLEN{sign_a & in_opa[XLEN-1]}}, in_opa};
    ext_b  = {{XLEN{sign_b & in_opb[XLEN-1]}}, in_opb};
  end

  // Intermediate stage registers; the output register acts as the last stage.
  logic             st_valid [NI];
  logic [W2-1:0]    st_psum  [NI];
  logic [W2-1:0]    st_ea    [NI];
  logic [W2-1:0]    st_eb    [NI];
  logic [1:0]       st_func  [NI];
  logic [PRN_W-1:0] st_prn   [NI];
  logic [ROB_W-1:0] st_rob   [NI];

  logic             src_valid [NUM_STAGES];
  logic [W2-1:0]    src_psum  [NUM_STAGES];
  logic [W2-1:0]    src_ea    [NUM_STAGES];
  logic [W2-1:0]    src_eb    [NUM_STAGES];
  logic [1:0]       src_func  [NUM_STAGES];
  logic [PRN_W-1:0] src_prn   [NUM_STAGES];
  logic [ROB_W-1:0] src_rob   [NUM_STAGES];
  logic [W2-1:0]    nxt_psum  [NUM_STAGES];
  logic [XLEN-1:0]  res_sel;

  // Remaining multiplier bits are pre-shifted, so every stage uses the low C bits.
  always_comb begin
    src_valid[0] = in_valid;
    src_psum[0]  = '0;
    src_ea[0]    = ext_a;
    src_eb[0]    = ext_b;
    src_func[0]  = in_func;
    src_prn[0]   = in_prn;
    src_rob[0]   = in_rob;
    for (int k = 1; k < NUM_STAGES; k++) begin
      src_valid[k] = st_valid[k-1];
      src_psum[k]  = st_psum[k-1];
      src_ea[k]    = st_ea[k-1];
      src_eb[k]    = st_eb[k-1];
      src_func[k]  = st_func[k-1];
      src_prn[k]   = st_prn[k-1];
      src_rob[k]   = st_rob[k-1];
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      nxt_psum[k] = src_psum[k]
                  + ((src_ea[k] * {{(W2-C){1'b0}}, src_eb[k][C-1:0]}) << (k * C));
    end
    res_sel = (src_func[NI] == F_MUL) ? nxt_psum[NI][XLEN-1:0]
                                      : nxt_psum[NI][W2-1:XLEN];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NI; k++) begin
        st_valid[k] <= 1'b0;
        st_psum[k]  <= '0;
        st_ea[k]    <= '0;
        st_eb[k]    <= '0;
        st_func[k]  <= '0;
        st_prn[k]   <= '0;
        st_rob[k]   <= '0;
      end
      out_valid  <= 1'b0;
      out_result <= '0;
      out_prn    <= '0;
      out_rob    <= '0;
    end else begin
      if (adv) begin
        for (int k = 0; k < NI; k++) begin
          st_valid[k] <= src_valid[k];
          st_psum[k]  <= nxt_psum[k];
          st_ea[k]    <= src_ea[k];
          st_eb[k]    <= src_eb[k] >> C;
          st_func[k]  <= src_func[k];
          st_prn[k]   <= src_prn[k];
          st_rob[k]   <= src_rob[k];
        end
        out_valid  <= src_valid[NI];
        out_result <= res_sel;
        out_prn    <= src_prn[NI];
        out_rob    <= src_rob[NI];
      end
      // Squash overrides the shift: only valids are killed, data may linger.
      if (squash) begin
        for (int k = 0; k < NI; k++) st_valid[k] <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: latency, op variants, streaming, stall, squash, async reset.
module tb_mult_fu;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_opa;
  logic [31:0] in_opb;
  logic [1:0]  in_func;
  logic [5:0]  in_prn;
  logic [4:0]  in_rob;
  logic        squash;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_prn;
  logic [4:0]  out_rob;

  int n_cmp = 0;
  int n_err = 0;

  mult_fu #(.XLEN(32), .NUM_STAGES(4), .PRN_W(6), .ROB_W(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func),
    .in_prn(in_prn), .in_rob(in_rob), .squash(squash),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_prn(out_prn), .out_rob(out_rob)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                       input logic [5:0] p, input logic [4:0] r);
    in_valid = 1'b1;
    in_opa   = a;
    in_opb   = b;
    in_func  = f;
    in_prn   = p;
    in_rob   = r;
  endtask

  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] f, input logic [5:0] p, input logic [4:0] r,
                        input logic [31:0] exp);
    issue(a, b, f, p, r);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, out_result, exp);
    chk({tag, "_prn"}, {26'd0, out_prn}, {26'd0, p});
    chk({tag, "_rob"}, {27'd0, out_rob}, {27'd0, r});
    step();
    chk({tag, "_gone"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_opa    = '0;
    in_opb    = '0;
    in_func   = '0;
    in_prn    = '0;
    in_rob    = '0;
    squash    = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_prn", {26'd0, out_prn}, 32'd0);
    chk("rst_rob", {27'd0, out_rob}, 32'd0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single ops, unstalled, latency 4
    single("mul_7xm3", 32'h0000_0007, 32'hFFFF_FFFD, 2'd0, 6'd5,  5'd17, 32'hFFFF_FFEB);
    single("mulh_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 6'd33, 5'd1,  32'h0000_0000);
    single("mulhsu_m1",32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 6'd34, 5'd2,  32'hFFFF_FFFF);
    single("mulhu_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 6'd35, 5'd3,  32'hFFFF_FFFE);
    single("mulh_min", 32'h8000_0000, 32'h8000_0000, 2'd1, 6'd63, 5'd31, 32'h4000_0000);
    single("mul_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 6'd7,  5'd8,  32'h0000_0001);
    single("mul_zero", 32'h1234_5678, 32'h0000_0000, 2'd0, 6'd9,  5'd10, 32'h0000_0000);
    single("mulhu_big",32'h1234_5678, 32'h9ABC_DEF0, 2'd3, 6'd11, 5'd12, 32'h0B00_EA4E);

    // Six back-to-back MULs: (i+2)*3, tags 10+i
    for (int c = 0; c < 10; c++) begin
      if (c < 6) issue(32'(c + 2), 32'd3, 2'd0, 6'(10 + c), 5'(c));
      else in_valid = 1'b0;
      if (c >= 4) begin
        chk($sformatf("b2b_valid_%0d", c - 4), {31'd0, out_valid}, 32'd1);
        chk($sformatf("b2b_result_%0d", c - 4), out_result, 32'((c - 2) * 3));
        chk($sformatf("b2b_prn_%0d", c - 4), {26'd0, out_prn}, 32'(10 + c - 4));
      end
      step();
    end
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Stall: 4 ops in flight, out_ready low for cycles 4..6
    for (int c = 0; c < 12; c++) begin
      if (c < 4) issue(32'(100 + c), 32'd2, 2'd0, 6'(20 + c), 5'(20 + c));
      else in_valid = 1'b0;
      out_ready = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 10) begin
        automatic int idx = (c <= 7) ? 0 : c - 7;
        chk($sformatf("stall_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
        chk($sformatf("stall_result_c%0d", c), out_result, 32'((100 + idx) * 2));
        chk($sformatf("stall_rob_c%0d", c), {27'd0, out_rob}, 32'(20 + idx));
      end
      if (c >= 4 && c <= 7)
        chk($sformatf("stall_in_ready_c%0d", c), {31'd0, in_ready}, (c <= 6) ? 32'd0 : 32'd1);
      if (c == 11) chk("stall_drained", {31'd0, out_valid}, 32'd0);
      step();
    end
    out_ready = 1'b1;

    // Squash: 3 ops in flight, 4th presented with squash, 5th issued after
    for (int c = 0; c < 10; c++) begin
      squash = 1'b0;
      if (c < 4) issue(32'(50 + c), 32'd5, 2'd0, 6'(40 + c), 5'(c));
      else if (c == 4) issue(32'd9, 32'd9, 2'd0, 6'd50, 5'd25);
      else in_valid = 1'b0;
      if (c == 3) begin
        squash = 1'b1;
        chk("sq_in_ready", {31'd0, in_ready}, 32'd1);
      end
      if (c >= 4 && c <= 7)
        chk($sformatf("sq_quiet_c%0d", c), {31'd0, out_valid}, 32'd0);
      if (c == 8) begin
        chk("sq_post_valid", {31'd0, out_valid}, 32'd1);
        chk("sq_post_result", out_result, 32'd81);
        chk("sq_post_prn", {26'd0, out_prn}, 32'd50);
      end
      if (c == 9) chk("sq_post_single", {31'd0, out_valid}, 32'd0);
      step();
    end
    squash = 1'b0;

    // Async reset mid-cycle with results held at the output
    out_ready = 1'b0;
    issue(32'd3, 32'd4, 2'd0, 6'd1, 5'd1);
    step();
    issue(32'd5, 32'd6, 2'd0, 6'd2, 5'd2);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("ar_pre_result", out_result, 32'd12);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_drop_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_drop_result", out_result, 32'd0);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("ar_quiet_%0d", c), {31'd0, out_valid}, 32'd0);
    end
    single("ar_new", 32'd11, 32'd13, 2'd0, 6'd3, 5'd4, 32'd143);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply functional unit in the execute stage, alongside the ALU.
- Takes all RV32M multiply ops (MUL, MULH, MULHSU, MULHU), which the ALU does not handle, from the issue stage.
- Carries the destination physical-register tag and ROB index through the pipe.
- Presents the finished result to the complete/CDB arbiter with a valid/ready handshake.
- Fully pipelined: accepts one op per cycle; supports squash on branch mispredict.

Parameters:
- XLEN, 32, operand/result width.
- NUM_STAGES, 4, pipeline depth; must divide 2*XLEN. Each stage accumulates 2*XLEN/NUM_STAGES multiplier bits.
- PRN_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline valids
- in_valid  in  1  issue presents an op
- in_ready  out  1  unit can accept this cycle
- in_opa  in  XLEN  rs1 value
- in_opb  in  XLEN  rs2 value
- in_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
- in_prn  in  PRN_W  destination tag
- in_rob  in  ROB_W  ROB index
- squash  in  1  mispredict flush; kills every in-flight op
- out_valid  out  1  result available
- out_ready  in  1  CDB arbiter accepts result
- out_result  out  XLEN  product slice
- out_prn  out  PRN_W  tag of the result
- out_rob  out  ROB_W  ROB index of the result

Behaviour:
- Reset (async, immediate on assertion):
  - All stage valid bits = 0; out_valid = 0.
  - out_result, out_prn, out_rob = 0.
  - in_ready = 1 once reset deasserts.
- Operand extension at accept, to 2*XLEN bits:
  - opa is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - opb is sign-extended for MULH only.
  - MUL uses zero extension; its low half is sign-agnostic.
- Product:
  - Full product = ext_a * ext_b mod 2^(2*XLEN).
  - Stage k (0-based) adds ext_a * ext_b[k*C +: C] << (k*C), where C = 2*XLEN/NUM_STAGES.
  - Stage registers carry: partial sum, ext_a, remaining ext_b, func, prn, rob, valid.
- Result selection at the final stage:
  - MUL returns product[XLEN-1:0].
  - All other ops return product[2*XLEN-1:XLEN].
- Advance and handshake:
  - advance = !out_valid || out_ready. All stages shift together when advance = 1 and freeze when it is 0.
  - in_ready = advance. An accept happens when in_valid && in_ready.
  - A bubble (valid = 0) enters stage 0 when no accept occurs.
- Latency and throughput:
  - Op accepted at cycle T appears with out_valid = 1 in cycle T+NUM_STAGES if never stalled.
  - Each stall cycle adds exactly one cycle.
  - Back-to-back issue sustains one result per cycle.
- Output register:
  - out_* hold stable while out_valid && !out_ready.
  - A result is consumed only on out_valid && out_ready.
- Squash:
  - On a clock edge with squash = 1, every stage valid and out_valid are cleared, including a result being accepted that same edge.
  - An op presented on in_valid that cycle is discarded.
  - in_ready is unaffected by squash.
  - Data fields need not be cleared.
- Reset mid-operation: all in-flight ops are lost; there is no partial output.
- Operand special cases, no special handling needed:
  - opb = 0 yields 0.
  - 0x80000000 * 0x80000000 under MULH yields 0x40000000.
  - Overflow wraps modulo 2^(2*XLEN).
- No internal combinational path from in_* to out_*. in_ready depends combinationally only on out_valid and out_ready.

Test Plan:
- MUL 7 * (-3) (0x00000007, 0xFFFFFFFD), no stall -> out_valid at T+4, result 0xFFFFFFEB, prn and rob echoed.
- MULH, MULHSU, MULHU with opa = opb = 0xFFFFFFFF -> 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively; MULH 0x80000000 * 0x80000000 -> 0x40000000.
- Issue 6 ops back-to-back with out_ready = 1 -> 6 consecutive out_valid cycles, in order, correct tags.
- Hold out_ready = 0 for 3 cycles with 4 ops in flight -> in_ready = 0, outputs stable, no loss or duplication; after release, all 4 drain in order.
- Assert squash for 1 cycle with 3 ops in flight plus one presented -> out_valid stays 0 for the next NUM_STAGES cycles; an op issued the cycle after squash completes normally.
- Assert reset asynchronously mid-cycle with 2 ops in flight -> out_valid drops immediately, no output after reset release until a new op completes.
